// File: rtl/sync_debounce.sv
// Multi-channel input synchroniser with per-channel debounce filter
// and registered rise/fall strobes aligned with the debounced level.
module sync_debounce #(
   parameter int unsigned     N_CH            = 4,
   parameter int unsigned     SYNC_FF_STAGE   = 3,
   parameter int unsigned     DEBOUNCE_CYCLES = 16,
   parameter logic [N_CH-1:0] RST_VAL         = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N_CH-1:0] in_async_i,
   output logic [N_CH-1:0] out_sync_o,
   output logic [N_CH-1:0] rise_o,
   output logic [N_CH-1:0] fall_o
);

   localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   if (N_CH == 0) begin : g_bad_nch
      $error("sync_debounce: N_CH must be >= 1");
   end
   if (SYNC_FF_STAGE < 2) begin : g_bad_sync
      $error("sync_debounce: SYNC_FF_STAGE must be >= 2");
   end
   if (DEBOUNCE_CYCLES == 0) begin : g_bad_deb
      $error("sync_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      (* ASYNC_REG = "TRUE" *)
      logic [SYNC_FF_STAGE-1:0] sync_q;
      logic [CW-1:0]            cnt_q, cnt_d;
      logic                     out_q, out_d;
      logic                     rise_q, rise_d;
      logic                     fall_q, fall_d;
      logic                     s;

      assign s = sync_q[SYNC_FF_STAGE-1];

      // Plain shift-register synchroniser, no logic between stages
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            sync_q <= {SYNC_FF_STAGE{RST_VAL[i]}};
         end else begin
            sync_q <= {sync_q[SYNC_FF_STAGE-2:0], in_async_i[i]};
         end
      end

      // Debounce: count mismatching cycles, commit on terminal count
      always_comb begin
         cnt_d  = '0;
         out_d  = out_q;
         rise_d = 1'b0;
         fall_d = 1'b0;
         if (s != out_q) begin
            if (cnt_q == CNT_MAX) begin
               out_d  = s;
               rise_d = s;
               fall_d = ~s;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      // Filter state and strobe registers
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            cnt_q  <= '0;
            out_q  <= RST_VAL[i];
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
         end
      end

      assign out_sync_o[i] = out_q;
      assign rise_o[i]     = rise_q;
      assign fall_o[i]     = fall_q;
   end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: default configuration plus a
// minimal-latency instance (2 sync stages, no filtering).
module tb_sync_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_a, out, rise, fall;
   logic [3:0] in2, out2, rise2, fall2;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   sync_debounce dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_async_i (in_a),
      .out_sync_o (out),
      .rise_o     (rise),
      .fall_o     (fall)
   );

   sync_debounce #(
      .N_CH            (4),
      .SYNC_FF_STAGE   (2),
      .DEBOUNCE_CYCLES (1),
      .RST_VAL         (4'h0)
   ) dut2 (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_async_i (in2),
      .out_sync_o (out2),
      .rise_o     (rise2),
      .fall_o     (fall2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] eo, er;
      rst_n = 1'b0;
      in_a  = 4'hF;
      in2   = 4'h0;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d out=%h rise=%h fall=%h required 0/0/0",
                     c, out, rise, fall);
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         eo = (e >= 19) ? 4'hF : 4'h0;
         er = (e == 19) ? 4'hF : 4'h0;
         checks++;
         if (out !== eo || rise !== er || fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_release edge=%0d out=%h rise=%h fall=%h required %h/%h/0",
                     e, out, rise, fall, eo, er);
         end
      end
   endtask

   task automatic test_fall_all();
      logic [3:0] eo, ef;
      in_a = 4'h0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         eo = (e >= 19) ? 4'h0 : 4'hF;
         ef = (e == 19) ? 4'hF : 4'h0;
         checks++;
         if (out !== eo || fall !== ef || rise !== 4'h0) begin
            errors++;
            $display("FAIL fall_all edge=%0d out=%h rise=%h fall=%h required %h/0/%h",
                     e, out, rise, fall, eo, ef);
         end
      end
   endtask

   task automatic test_rise_ch0();
      logic [3:0] eo, er;
      in_a = 4'b0001;
      for (int e = 1; e <= 20; e++) begin
         tick();
         eo = (e >= 19) ? 4'b0001 : 4'h0;
         er = (e == 19) ? 4'b0001 : 4'h0;
         checks++;
         if (out !== eo || rise !== er || fall !== 4'h0) begin
            errors++;
            $display("FAIL rise_ch0 edge=%0d out=%h rise=%h fall=%h required %h/%h/0",
                     e, out, rise, fall, eo, er);
         end
      end
   endtask

   task automatic test_glitch();
      for (int c = 0; c < 40; c++) begin
         in_a = (c < 10) ? 4'b0011 : 4'b0001;
         tick();
         checks++;
         if (out !== 4'b0001 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL glitch_ch1 cyc=%0d out=%h rise=%h fall=%h required 1/0/0",
                     c, out, rise, fall);
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] eo, er;
      for (int k = 0; k < 8; k++) begin
         in_a = (k % 2 == 0) ? 4'b0101 : 4'b0001;
         for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out !== 4'b0001 || rise !== 4'h0 || fall !== 4'h0) begin
               errors++;
               $display("FAIL bounce_ch2 seg=%0d cyc=%0d out=%h rise=%h fall=%h required 1/0/0",
                        k, c, out, rise, fall);
            end
         end
      end
      in_a = 4'b0101;
      for (int e = 1; e <= 20; e++) begin
         tick();
         eo = (e >= 19) ? 4'b0101 : 4'b0001;
         er = (e == 19) ? 4'b0100 : 4'h0;
         checks++;
         if (out !== eo || rise !== er || fall !== 4'h0) begin
            errors++;
            $display("FAIL bounce_settle edge=%0d out=%h rise=%h fall=%h required %h/%h/0",
                     e, out, rise, fall, eo, er);
         end
      end
   endtask

   task automatic test_reset_midcount();
      in_a = 4'b1101;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (out !== 4'b0101 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL midcount_pre cyc=%0d out=%h rise=%h fall=%h required 5/0/0",
                     c, out, rise, fall);
         end
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
         errors++;
         $display("FAIL midcount_reset out=%h rise=%h fall=%h required 0/0/0",
                  out, rise, fall);
      end
      in_a  = 4'h0;
      rst_n = 1'b1;
      for (int c = 0; c < 25; c++) begin
         tick();
         checks++;
         if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL midcount_after cyc=%0d out=%h rise=%h fall=%h required 0/0/0",
                     c, out, rise, fall);
         end
      end
   endtask

   task automatic test_fast_cfg();
      logic [3:0] eo, es;
      in2 = 4'b0001;
      for (int e = 1; e <= 4; e++) begin
         tick();
         eo = (e >= 3) ? 4'b0001 : 4'h0;
         es = (e == 3) ? 4'b0001 : 4'h0;
         checks++;
         if (out2 !== eo || rise2 !== es || fall2 !== 4'h0) begin
            errors++;
            $display("FAIL fast_rise edge=%0d out=%h rise=%h fall=%h required %h/%h/0",
                     e, out2, rise2, fall2, eo, es);
         end
      end
      in2 = 4'b0000;
      for (int e = 1; e <= 4; e++) begin
         tick();
         eo = (e >= 3) ? 4'h0 : 4'b0001;
         es = (e == 3) ? 4'b0001 : 4'h0;
         checks++;
         if (out2 !== eo || fall2 !== es || rise2 !== 4'h0) begin
            errors++;
            $display("FAIL fast_fall edge=%0d out=%h rise=%h fall=%h required %h/0/%h",
                     e, out2, rise2, fall2, eo, es);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_a  = 4'h0;
      in2   = 4'h0;
      test_reset();
      test_fall_all();
      test_rise_ch0();
      test_glitch();
      test_bounce();
      test_reset_midcount();
      test_fast_cfg();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Multi-channel synchroniser with a per-channel debounce filter and edge-pulse outputs, the parametrised successor of the single-bit flip-flop synchroniser. It sits directly behind board-level asynchronous inputs such as buttons, switches and external status lines. It gives downstream logic a clean, glitch-free level plus single-cycle rise/fall strobes, all in the `clk_i` domain.

## Interface
- `N_CH`, default 4: number of independent channels; must be ≥ 1.
- `SYNC_FF_STAGE`, default 3: synchroniser flip-flops per channel; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a new synchronised value must hold before the output follows. Must be ≥ 1; 1 means no filtering.
- `RST_VAL`, default '0 (`N_CH` bits): reset value of every sync stage and of `out_sync_o`, per channel.
- Out-of-range parameters are an elaboration-time error.
- `clk_i`  input  1  sole clock.
- `rst_ni`  input  1  reset, synchronous, active-low.
- `in_async_i`  input  `N_CH`  asynchronous inputs, one bit per channel.
- `out_sync_o`  output  `N_CH`  synchronised, debounced level (registered).
- `rise_o`  output  `N_CH`  one-cycle strobe when `out_sync_o[i]` goes 0→1 (registered).
- `fall_o`  output  `N_CH`  one-cycle strobe when `out_sync_o[i]` goes 1→0 (registered).

## Operation
- Channels are fully independent; each holds a sync chain, a stable register (drives `out_sync_o[i]`) and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Sync chain is a shift register.
  - Bit 0 samples `in_async_i[i]`.
  - The last stage is the synchronised value `s[i]`.
  - No logic is permitted between chain stages.
- Per channel, on each `clk_i` edge with `rst_ni` high:
  - `s == out`: counter ← 0; no change.
  - `s != out` and counter < `DEBOUNCE_CYCLES-1`: counter ← counter+1.
  - `s != out` and counter == `DEBOUNCE_CYCLES-1`: out ← `s`, counter ← 0, and the matching strobe (`rise_o`/`fall_o`) ← 1.
  - All other cycles: `rise_o[i]` and `fall_o[i]` ← 0.
- Effectively a two-state machine per channel:
  - STABLE (counter 0) → PENDING (counter > 0) on mismatch.
  - PENDING → STABLE on match (glitch rejected) or on terminal count (output updated).
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches `out_sync_o` and never produces a strobe.
- `rise_o[i]` and `fall_o[i]` are never high together and never high on two consecutive cycles with `DEBOUNCE_CYCLES` ≥ 2.
- Reset (`rst_ni` low at an edge):
  - all sync stages and `out_sync_o` ← `RST_VAL`;
  - counters ← 0; `rise_o`, `fall_o` ← 0.
  - Reset itself never produces a strobe.
  - Reset mid-count discards the pending transition.

## Timing
- Input change to `out_sync_o` change, with the input held clean: exactly `SYNC_FF_STAGE + DEBOUNCE_CYCLES` rising edges, counting the first edge that samples the new value. Default: 19.
- The strobe asserts on the same edge that `out_sync_o` changes and lasts exactly one cycle, so it is aligned with the new level.
- If the input differs from `RST_VAL` when reset releases, the first transition follows the same latency after release, with its strobe.
- After a bouncing input settles, latency is measured from the last transition.
- Metastability resolution is one cycle per stage. Sync chain registers carry an ASYNC_REG attribute.

## Test plan
- Reset, defaults, `in_async_i`=4'hF held, `rst_ni` low 2 cycles: `out_sync_o`=0, `rise_o`=`fall_o`=0 during reset and on the first cycle after.
- Clean rise on ch0 after reset: `out_sync_o[0]`=1 on exactly the 19th edge; `rise_o`=4'b0001 for that one cycle only; other channels unchanged.
- Glitch on ch1 high for 10 cycles then low: `out_sync_o` and all strobes stay 0 throughout.
- Bounce on ch2, toggling every 5 cycles for 40 cycles, then held 1: one rise, 19 edges after the final toggle; `rise_o[2]` pulses once.
- All four channels at 1 fall in the same cycle: `fall_o`=4'hF for exactly one cycle, 19 edges later.
- `SYNC_FF_STAGE`=2, `DEBOUNCE_CYCLES`=1: rise visible after 3 edges. Separately, asserting `rst_ni` low mid-count in the default config: no strobe, `out_sync_o`=`RST_VAL`.
